// File: rtl/ad_bus_responder.sv
// Multiplexed address/data bus responder with a 16x8 register file and
// programmable wait states; every output is registered.
module ad_bus_responder #(
    parameter logic [3:0] BASE_ADDR   = 4'hA,
    parameter int         WAIT_STATES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ALE,
    input  logic       rd,
    input  logic       wr,
    input  logic [7:0] bus_in,
    output logic [7:0] bus_out,
    output logic [7:0] bus_en,
    output logic       ready,
    output logic       sel,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        RD_WAIT,
        RD_DRIVE,
        WR_WAIT,
        WR_DONE
    } state_t;

    localparam logic [1:0] WS      = 2'(WAIT_STATES);
    localparam bit         NO_WAIT = (WAIT_STATES == 0);

    state_t     state;
    state_t     next_state;
    // Only the index nibble is needed once the decode into sel has been made.
    logic [3:0] addr;
    logic [1:0] wcnt;
    logic [7:0] mem [16];

    logic do_write;
    logic load_wcnt;
    logic set_err;

    always_comb begin
        next_state = state;
        do_write   = 1'b0;
        load_wcnt  = 1'b0;
        set_err    = 1'b0;

        if (ALE) begin
            next_state = ADDR;
        end else begin
            case (state)
                IDLE: next_state = IDLE;

                // An unselected responder ignores both strobes until the next ALE.
                ADDR: begin
                    if (sel) begin
                        if (rd && wr) begin
                            set_err    = 1'b1;
                            next_state = IDLE;
                        end else if (rd) begin
                            load_wcnt  = 1'b1;
                            next_state = NO_WAIT ? RD_DRIVE : RD_WAIT;
                        end else if (wr) begin
                            if (NO_WAIT) begin
                                do_write   = 1'b1;
                                next_state = WR_DONE;
                            end else begin
                                load_wcnt  = 1'b1;
                                next_state = WR_WAIT;
                            end
                        end
                    end
                end

                RD_WAIT: begin
                    if (rd && wr) begin
                        set_err    = 1'b1;
                        next_state = IDLE;
                    end else if (!rd) begin
                        next_state = IDLE;
                    end else if (wcnt == 2'd1) begin
                        next_state = RD_DRIVE;
                    end
                end

                RD_DRIVE: begin
                    if (rd && wr) begin
                        set_err    = 1'b1;
                        next_state = IDLE;
                    end else if (!rd) begin
                        next_state = IDLE;
                    end
                end

                WR_WAIT: begin
                    if (rd && wr) begin
                        set_err    = 1'b1;
                        next_state = IDLE;
                    end else if (!wr) begin
                        next_state = IDLE;
                    end else if (wcnt == 2'd1) begin
                        do_write   = 1'b1;
                        next_state = WR_DONE;
                    end
                end

                WR_DONE: begin
                    if (rd && wr) begin
                        set_err    = 1'b1;
                        next_state = IDLE;
                    end else if (!wr) begin
                        next_state = IDLE;
                    end
                end

                default: next_state = IDLE;
            endcase
        end
    end

    // Outputs are computed from next_state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr    <= 4'h0;
            wcnt    <= 2'd0;
            sel     <= 1'b0;
            err     <= 1'b0;
            ready   <= 1'b1;
            bus_en  <= 8'h00;
            bus_out <= 8'h00;
            for (int i = 0; i < 16; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            state <= next_state;

            if (ALE) begin
                addr <= bus_in[3:0];
                sel  <= (bus_in[7:4] == BASE_ADDR);
            end

            if (load_wcnt) begin
                wcnt <= WS;
            end else if (state == RD_WAIT || state == WR_WAIT) begin
                wcnt <= wcnt - 2'd1;
            end

            if (set_err) begin
                err <= 1'b1;
            end

            if (do_write) begin
                mem[addr] <= bus_in;
            end

            ready   <= !(next_state == RD_WAIT || next_state == WR_WAIT);
            bus_en  <= (next_state == RD_DRIVE) ? 8'hFF : 8'h00;
            bus_out <= (next_state == RD_DRIVE) ? mem[addr] : 8'h00;
        end
    end

endmodule

// File: tb/tb_ad_bus_responder.sv
// Scoreboard bench for ad_bus_responder: one instance with one wait state,
// one with three; read data is checked by per-instance monitors.
module tb_ad_bus_responder;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       ale    = 1'b0;
    logic       rd     = 1'b0;
    logic       wr     = 1'b0;
    logic       use3   = 1'b0;
    logic [7:0] bus_in = 8'h00;

    logic [7:0] bus_out1, bus_en1, bus_out3, bus_en3;
    logic       ready1, sel1, err1, ready3, sel3, err3;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] exp_q1 [$];
    logic [7:0] exp_q3 [$];
    logic [7:0] prev_en1 = 8'h00;
    logic [7:0] prev_en3 = 8'h00;

    always #5 clk = ~clk;

    ad_bus_responder #(.BASE_ADDR(4'hA), .WAIT_STATES(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .ALE(ale & ~use3), .rd(rd & ~use3), .wr(wr & ~use3), .bus_in(bus_in),
        .bus_out(bus_out1), .bus_en(bus_en1), .ready(ready1), .sel(sel1), .err(err1)
    );

    ad_bus_responder #(.BASE_ADDR(4'hA), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .ALE(ale & use3), .rd(rd & use3), .wr(wr & use3), .bus_in(bus_in),
        .bus_out(bus_out3), .bus_en(bus_en3), .ready(ready3), .sel(sel3), .err(err3)
    );

    function automatic logic [7:0] cur_en();
        return use3 ? bus_en3 : bus_en1;
    endfunction

    function automatic logic [7:0] cur_out();
        return use3 ? bus_out3 : bus_out1;
    endfunction

    function automatic logic cur_ready();
        return use3 ? ready3 : ready1;
    endfunction

    task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic a, input logic r, input logic w, input logic [7:0] d);
        ale    = a;
        rd     = r;
        wr     = w;
        bus_in = d;
        tick();
    endtask

    task automatic push_expected(input logic [7:0] d);
        if (use3) exp_q3.push_back(d);
        else      exp_q1.push_back(d);
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] expected, input int ws);
        int low = 0;
        int n   = 0;
        apply_stimulus(1'b1, 1'b0, 1'b0, a);
        push_expected(expected);
        apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);
        while (cur_en() != 8'hFF && n < 10) begin
            if (!cur_ready()) low++;
            tick();
            n++;
        end
        check_output("read_reached_drive", cur_en(), 8'hFF);
        check_output("read_ready_low_cycles", 8'(low), 8'(ws));
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
        check_output("read_release_bus_en", cur_en(), 8'h00);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int ws);
        int low = 0;
        apply_stimulus(1'b1, 1'b0, 1'b0, a);
        apply_stimulus(1'b0, 1'b0, 1'b1, d);
        while (!cur_ready() && low < 10) begin
            low++;
            tick();
        end
        check_output("write_ready_low_cycles", 8'(low), 8'(ws));
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    // Each fresh assertion of bus_en consumes one expected read value.
    always @(negedge clk) begin
        if (bus_en1 == 8'hFF && prev_en1 != 8'hFF) begin
            if (exp_q1.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_drive1: got %h, expected no drive", bus_out1);
            end else begin
                check_output("read_data1", bus_out1, exp_q1.pop_front());
            end
        end
        prev_en1 <= bus_en1;
    end

    always @(negedge clk) begin
        if (bus_en3 == 8'hFF && prev_en3 != 8'hFF) begin
            if (exp_q3.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_drive3: got %h, expected no drive", bus_out3);
            end else begin
                check_output("read_data3", bus_out3, exp_q3.pop_front());
            end
        end
        prev_en3 <= bus_en3;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #12;
        check_output("reset_sel", {7'd0, sel1}, 8'h00);
        check_output("reset_err", {7'd0, err1}, 8'h00);
        check_output("reset_ready", {7'd0, ready1}, 8'h01);
        check_output("reset_bus_en", bus_en1, 8'h00);
        check_output("reset_bus_out", bus_out1, 8'h00);
        rst_n = 1'b1;
        tick();

        // Single wait-state read of an untouched location
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'hA3);
        check_output("rd_sel", {7'd0, sel1}, 8'h01);
        check_output("rd_addr_ready", {7'd0, ready1}, 8'h01);
        push_expected(8'h00);
        apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);
        check_output("rd_wait_ready", {7'd0, ready1}, 8'h00);
        check_output("rd_wait_bus_en", bus_en1, 8'h00);
        apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);
        check_output("rd_drive_ready", {7'd0, ready1}, 8'h01);
        check_output("rd_drive_bus_en", bus_en1, 8'hFF);
        check_output("rd_drive_bus_out", bus_out1, 8'h00);
        apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);
        check_output("rd_hold_bus_en", bus_en1, 8'hFF);
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
        check_output("rd_end_bus_en", bus_en1, 8'h00);
        check_output("rd_end_bus_out", bus_out1, 8'h00);

        // Write then read back, and scan every entry
        do_write(8'hA5, 8'h3C, 1);
        do_read(8'hA5, 8'h3C, 1);
        for (int i = 0; i < 16; i++) begin
            do_read({4'hA, 4'(i)}, (i == 5) ? 8'h3C : 8'h00, 1);
        end

        // Unselected address ignores strobes
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'h53);
        check_output("nosel_sel", {7'd0, sel1}, 8'h00);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, 1'b1, 1'b0, 8'h53);
            check_output("nosel_sel_hold", {7'd0, sel1}, 8'h00);
            check_output("nosel_ready", {7'd0, ready1}, 8'h01);
            check_output("nosel_bus_en", bus_en1, 8'h00);
        end
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);

        // Simultaneous strobes: sticky error, back to IDLE
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'hA7);
        apply_stimulus(1'b0, 1'b1, 1'b1, 8'h99);
        check_output("err_set", {7'd0, err1}, 8'h01);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);
            check_output("err_idle_ready", {7'd0, ready1}, 8'h01);
            check_output("err_idle_bus_en", bus_en1, 8'h00);
        end
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
        check_output("err_sticky", {7'd0, err1}, 8'h01);
        do_read(8'hA7, 8'h00, 1);
        check_output("err_sticky_after_read", {7'd0, err1}, 8'h01);

        // Three wait-state instance: aborted read, aborted write, normal access
        use3 = 1'b1;
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'hA4);
        apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);
        check_output("abort_rd_wait_ready", {7'd0, ready3}, 8'h00);
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
        check_output("abort_rd_ready", {7'd0, ready3}, 8'h01);
        check_output("abort_rd_bus_en", bus_en3, 8'h00);
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
        check_output("abort_rd_bus_en_later", bus_en3, 8'h00);

        apply_stimulus(1'b1, 1'b0, 1'b0, 8'hA2);
        apply_stimulus(1'b0, 1'b0, 1'b1, 8'hFF);
        check_output("abort_wr_wait_ready", {7'd0, ready3}, 8'h00);
        apply_stimulus(1'b0, 1'b0, 1'b1, 8'hFF);
        apply_stimulus(1'b1, 1'b0, 1'b1, 8'hA2);
        check_output("abort_wr_ale_ready", {7'd0, ready3}, 8'h01);
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
        do_read(8'hA2, 8'h00, 3);
        do_write(8'hA4, 8'h5A, 3);
        do_read(8'hA4, 8'h5A, 3);
        use3 = 1'b0;

        // Asynchronous reset during RD_DRIVE releases the bus immediately
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'hA5);
        push_expected(8'h3C);
        apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);
        apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);
        check_output("rst_pre_bus_en", bus_en1, 8'hFF);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        rd    = 1'b0;
        #1;
        check_output("rst_async_bus_en", bus_en1, 8'h00);
        check_output("rst_async_ready", {7'd0, ready1}, 8'h01);
        check_output("rst_async_bus_out", bus_out1, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        do_read(8'hA5, 8'h00, 1);

        tick();
        tick();
        check_output("queue1_drained", 8'(exp_q1.size()), 8'h00);
        check_output("queue3_drained", 8'(exp_q3.size()), 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ad_bus_responder.md
AD_BUS_RESPONDER -- requirements
Module: ad_bus_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 4'hA: upper address nibble that selects this responder.
REQ-002 SHALL have parameter WAIT_STATES, default 1, legal range 0..3: number of ready-low cycles inserted per access.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port ALE, input, 1 bit: address latch enable; bus_in carries the address while ALE is high.
REQ-006 SHALL have port rd, input, 1 bit: active-high read strobe from the initiator.
REQ-007 SHALL have port wr, input, 1 bit: active-high write strobe from the initiator.
REQ-008 SHALL have port bus_in, input, 8 bits: multiplexed address/data bus as seen by the responder.
REQ-009 SHALL have port bus_out, output, 8 bits: read data driven toward the bus.
REQ-010 SHALL have port bus_en, output, 8 bits: per-bit drive enable for bus_out, either 8'hFF or 8'h00.
REQ-011 SHALL have port ready, output, 1 bit: low only while wait states are being inserted.
REQ-012 SHALL have port sel, output, 1 bit: latched address matched BASE_ADDR.
REQ-013 SHALL have port err, output, 1 bit: sticky protocol-error flag.

Function
REQ-014 SHALL treat all inputs as synchronous to clk and drive every output from registers, with no combinational input-to-output path.
REQ-015 SHALL contain a 16x8 register file indexed by the latched address bits [3:0].
REQ-016 SHALL use states IDLE, ADDR, RD_WAIT, RD_DRIVE, WR_WAIT and WR_DONE.
REQ-017 SHALL, on any edge with ALE=1 and in any state, latch addr<=bus_in, set sel<=(bus_in[7:4]==BASE_ADDR), go to ADDR, and abort any access in progress with no write performed.
REQ-018 SHALL give ALE priority over rd and wr on the same edge.
REQ-019 SHALL, from ADDR with sel=0, ignore rd and wr and remain in ADDR until the next ALE.
REQ-020 SHALL, from ADDR with sel=1, rd=1 and wr=0, load wcnt<=WAIT_STATES and go to RD_WAIT, or go directly to RD_DRIVE when WAIT_STATES=0.
REQ-021 SHALL, from ADDR with sel=1, wr=1 and rd=0, load wcnt<=WAIT_STATES and go to WR_WAIT; when WAIT_STATES=0 it SHALL instead write mem[addr[3:0]]<=bus_in on that edge and go to WR_DONE.
REQ-022 SHALL, in ADDR or any WAIT/DRIVE/DONE state with rd=1 and wr=1, set err<=1, perform no write, and go to IDLE.
REQ-023 SHALL, in RD_WAIT and WR_WAIT, decrement wcnt each edge.
REQ-024 SHALL leave RD_WAIT for RD_DRIVE on the edge where wcnt==1.
REQ-025 SHALL leave WR_WAIT on the edge where wcnt==1 by writing mem[addr[3:0]]<=bus_in on that same edge and going to WR_DONE.
REQ-026 SHALL make every read access hold ready low for exactly WAIT_STATES cycles.
REQ-027 SHALL make every write access hold ready low for exactly WAIT_STATES cycles.
REQ-028 SHALL, if the strobe deasserts during RD_WAIT or WR_WAIT, go to IDLE, perform no write, and never assert bus_en.
REQ-029 SHALL drive ready=0 exactly while in RD_WAIT or WR_WAIT, and ready=1 otherwise.
REQ-030 SHALL drive bus_en=8'hFF and bus_out=mem[addr[3:0]] exactly while in RD_DRIVE, and bus_en=8'h00 and bus_out=8'h00 otherwise.
REQ-031 SHALL remain in RD_DRIVE while rd=1, and go to IDLE on the first edge with rd=0 so that bus_en is 8'h00 in the following cycle.
REQ-032 SHALL remain in WR_DONE while wr=1, go to IDLE on wr=0, and perform exactly one write per access.
REQ-033 SHALL treat rd or wr asserted in IDLE, with no preceding ALE, as ignored, with no state change.
REQ-034 SHALL keep err at 1 once set, until reset.

Reset
REQ-035 SHALL, while rst_n=0 and regardless of clk, immediately force state=IDLE, addr=8'h00, wcnt=0, sel=0, err=0, ready=1, bus_en=8'h00, bus_out=8'h00, and all 16 mem entries to 8'h00.
REQ-036 SHALL, on reset asserted mid-access (including during RD_DRIVE), release bus_en within the same cycle without waiting for a clock edge.
REQ-037 SHALL resume normal operation on the first rising clk edge after rst_n returns to 1.

Verification
REQ-038 SHALL be verified with WAIT_STATES=1: ALE with bus_in=8'hA3, then rd=1 -> sel=1, ready=0 for 1 cycle, then bus_en=8'hFF and bus_out=8'h00 until rd=0, then bus_en=8'h00 one cycle later.
REQ-039 SHALL be verified by: ALE with 8'hA5, then wr=1 with bus_in=8'h3C, then ALE with 8'hA5 and rd=1 -> bus_out=8'h3C with bus_en=8'hFF, and mem[5] is the only nonzero entry.
REQ-040 SHALL be verified by: ALE with 8'h53, then rd=1 for 4 cycles -> sel=0, ready=1, bus_en=8'h00 throughout.
REQ-041 SHALL be verified by: ALE with 8'hA7, then rd=1 and wr=1 together -> err=1 and stays 1, a subsequent read of 8'hA7 returns 8'h00, and the state returns to IDLE.
REQ-042 SHALL be verified with WAIT_STATES=3: ALE with 8'hA2 and wr=1 with 8'hFF, then ALE reasserted during WR_WAIT -> no write occurs and mem[2]=8'h00.
REQ-043 SHALL be verified by: rst_n pulled low during RD_DRIVE -> bus_en=8'h00 and ready=1 before the next clk edge.
